// File: rtl/acc_uart_pkg.sv
// Shared types and constants for the accumulator UART transmitter.
package acc_uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int   BITS_PER_BYTE  = 8;
    localparam int   BYTES_PER_WORD = 2;
    localparam logic TX_IDLE_LEVEL  = 1'b1;
endpackage

// File: rtl/acc_uart_baud.sv
// Baud divider: bit_tick pulses on the last cycle of every CLKS_PER_BIT window.
// restart clears the count so the next window begins on the following cycle.
module acc_uart_baud #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = (cnt == LAST);
endmodule

// File: rtl/acc_uart_tx.sv
// Sends a captured 16-bit accumulator word as two UART frames, low byte first.
// Define ACC_UART_TX_PARITY_EN for 8E1 framing; default build is 8N1.
module acc_uart_tx
    import acc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] acc_in,
    input  logic              acc_valid,
    output logic              acc_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        byte_idx_q, byte_idx_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        capture;
    logic        bit_tick;
    logic [7:0]  cur_byte;

    assign capture  = acc_valid && (state_q == IDLE);
    assign cur_byte = byte_idx_q ? hold_q[15:8] : hold_q[7:0];

    // Restarting on capture aligns the first tick with the end of the start bit.
    acc_uart_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (capture),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = TX_IDLE_LEVEL;
                if (capture) begin
                    hold_d     = acc_in[15:0];
                    byte_idx_d = 1'b0;
                    bit_idx_d  = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    shreg_d   = cur_byte;
                    tx_d      = cur_byte[0];
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    shreg_d   = shreg_q >> 1;
                    if (bit_idx_q == 3'(BITS_PER_BYTE - 1)) begin
`ifdef ACC_UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^cur_byte;
`else
                        state_d = STOP;
                        tx_d    = TX_IDLE_LEVEL;
`endif
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end
            end
`ifdef ACC_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    tx_d    = TX_IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    // Second byte's start bit follows with no idle gap.
                    if (byte_idx_q == 1'(BYTES_PER_WORD - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        tx_d    = TX_IDLE_LEVEL;
                    end else begin
                        byte_idx_d = 1'b1;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = TX_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= 1'b0;
            tx_q       <= TX_IDLE_LEVEL;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx        = tx_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign acc_ready = !busy;
endmodule

// File: tb/tb_acc_uart_tx.sv
// Self-checking bench for acc_uart_tx; expected wire levels come from a frame-position model.
module tb_acc_uart_tx;
    localparam int CPB = 4;
`ifdef ACC_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = 2 * NB * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] acc_in = '0;
    logic        acc_valid = 1'b0;
    logic        acc_ready, tx, busy, done;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] word;
        bit          inject;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_hi;
    } vec_t;

    vec_t vecs[8];

    acc_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level t cycles after the first start bit begins.
    function automatic logic exp_tx(input logic [7:0] lo, input logic [7:0] hi, input int t);
        int bp, by, k;
        logic [7:0] b;
        bp = t / CPB;
        by = bp / NB;
        k  = bp % NB;
        b  = (by == 0) ? lo : hi;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == NB - 1) return 1'b1;
        return ^b;
    endfunction

    task automatic run_frame(input vec_t v);
        acc_in    = v.word;
        acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
        for (int t = 0; t < F; t++) begin
            check("frame_tx", tx, exp_tx(v.exp_lo, v.exp_hi, t));
            check("frame_busy", busy, 1);
            check("frame_done", done, 0);
            if (v.inject && t == F / 3) begin
                acc_in    = 16'hFFFF;
                acc_valid = 1'b1;
            end else if (v.inject && t == F / 3 + 1) begin
                acc_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_ready", acc_ready, 1);
        check("end_tx", tx, 1);
        acc_in = '0;
        @(negedge clk);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        int dcount, lowcount, p;
`ifdef ACC_UART_TX_PARITY_EN
        int lit[22] = '{0,0,0,1,0,1,1,0,0,1,1, 0,0,1,0,0,1,0,0,0,0,1};
`else
        int lit[20] = '{0,0,0,1,0,1,1,0,0,1, 0,0,1,0,0,1,0,0,0,1};
`endif
        vecs[0] = '{16'h1234, 1'b0, 8'h34, 8'h12};
        vecs[1] = '{16'h1234, 1'b1, 8'h34, 8'h12};
        vecs[2] = '{16'h0000, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{16'hFFFF, 1'b0, 8'hFF, 8'hFF};
        for (int i = 4; i < 8; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            vecs[i] = '{r, 1'($urandom_range(0, 1)), r[7:0], r[15:8]};
        end

        // Reset and idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 100; t++) begin
            check("idle_tx", tx, 1);
            check("idle_busy", busy, 0);
            check("idle_ready", acc_ready, 1);
            check("idle_done", done, 0);
            @(negedge clk);
        end

        // Literal wire pattern for 0x1234, sampled mid-bit
        acc_in = 16'h1234;
        acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
        for (int t = 0; t < F; t++) begin
            if (t % CPB == CPB / 2) check("lit_1234", tx, lit[t / CPB]);
            @(negedge clk);
        end
        check("lit_done", done, 1);
        @(negedge clk);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset during data bit 3 of byte 0
        acc_in = 16'h1234;
        acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
        for (int t = 0; t < 4 * CPB + 1; t++) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", acc_ready, 1);
        dcount = 0;
        lowcount = 0;
        for (int t = 0; t < 100; t++) begin
            if (done) dcount++;
            if (!tx) lowcount++;
            @(negedge clk);
        end
        check("rst_no_done", dcount, 0);
        check("rst_tx_quiet", lowcount, 0);
        run_frame('{16'h00FF, 1'b0, 8'hFF, 8'h00});

        // Back-to-back: a new word is captured in each done cycle
        acc_in = 16'hA55A;
        acc_valid = 1'b1;
        for (int t = 0; t < 3 * (F + 1); t++) begin
            p = t % (F + 1);
            check("b2b_ready", acc_ready, (p == 0) ? 1 : 0);
            check("b2b_done", done, (p == 0 && t > 0) ? 1 : 0);
            check("b2b_tx", tx, (p == 0) ? 1 : exp_tx(8'h5A, 8'hA5, p - 1));
            @(negedge clk);
        end
        acc_valid = 1'b0;
        check("b2b_last_done", done, 1);
        @(negedge clk);
        check("b2b_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
